// File: rtl/led_ring_monitor.sv
// led_ring_monitor
// Receive-side checker for the rotating one-hot LED ring pattern.
// Registers the pattern twice, decodes the lit position and tracks the
// step interval. A small FSM locks once two consecutive steps are
// rotate-left-by-one at the expected interval, then reports sequence and
// timing faults. Every output is registered, so led_in reaches each
// output after two clocks.
module led_ring_monitor #(
  parameter int unsigned C_MAX_COUNT = 32'd9_999_999,
  parameter int unsigned C_TOL       = 32'd2,
  parameter int unsigned CNT_W       = 32'd24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] led_in,
  input  logic        clr_err,
  output logic [3:0]  pos_out,
  output logic        pos_valid,
  output logic        step_pulse,
  output logic        err_onehot,
  output logic        err_seq,
  output logic        err_timing,
  output logic        err_sticky,
  output logic        locked
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Acceptance window for the interval count seen at a change; the lower
  // bound is clamped at zero when the tolerance exceeds the nominal count.
  localparam logic [CNT_W-1:0] HI_C = CNT_W'(C_MAX_COUNT + C_TOL);
  localparam logic [CNT_W-1:0] LO_C = (C_MAX_COUNT > C_TOL) ?
                                      CNT_W'(C_MAX_COUNT - C_TOL) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  // True when exactly one bit is set (all-zero is not one-hot).
  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
  endfunction

  // Index of the set bit; only meaningful for a one-hot input, where
  // OR-ing the indices of all set bits yields the single index.
  function automatic logic [3:0] encode(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = idx | (v[i] ? 4'(i) : 4'd0);
    end
    return idx;
  endfunction

  logic [15:0]      led_q_r;
  logic [15:0]      led_prev_r;
  logic [CNT_W-1:0] cnt_r;
  state_t           state_r;

  logic [15:0] exp_s;
  logic        chg_s;
  logic        seq_ok_s;
  logic        time_ok_s;
  logic        timeout_s;
  logic        prev_oh_s;
  logic        q_oh_s;
  logic        seq_err_s;
  logic        tim_err_s;
  logic        good_step_s;

  assign exp_s       = {led_prev_r[14:0], led_prev_r[15]};
  assign chg_s       = (led_q_r != led_prev_r);
  assign seq_ok_s    = (led_q_r == exp_s);
  assign time_ok_s   = (cnt_r >= LO_C) && (cnt_r <= HI_C);
  assign timeout_s   = !chg_s && (cnt_r == HI_C);
  assign prev_oh_s   = is_onehot(led_prev_r);
  assign q_oh_s      = is_onehot(led_q_r);
  assign good_step_s = chg_s && seq_ok_s && time_ok_s;
  // A wrong pattern takes priority over a timing fault on the same change.
  assign seq_err_s   = (state_r == ST_LOCKED) && chg_s && !seq_ok_s;
  assign tim_err_s   = (state_r == ST_LOCKED) &&
                       ((chg_s && seq_ok_s && !time_ok_s) || timeout_s);

  // Input pipeline and saturating interval counter restarted on each change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q_r    <= 16'h0000;
      led_prev_r <= 16'h0000;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      led_q_r    <= led_in;
      led_prev_r <= led_q_r;
      if (chg_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != CNT_MAX_C) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Position decode and one-hot flags, updated every cycle regardless of lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_out    <= 4'd0;
      pos_valid  <= 1'b0;
      err_onehot <= 1'b0;
    end else begin
      pos_valid  <= q_oh_s;
      err_onehot <= !q_oh_s;
      if (q_oh_s) begin
        pos_out <= encode(led_q_r);
      end else begin
        pos_out <= pos_out;
      end
    end
  end

  // Lock FSM with its registered step/error pulses and lock indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_SEARCH;
      step_pulse <= 1'b0;
      err_seq    <= 1'b0;
      err_timing <= 1'b0;
      locked     <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      err_seq    <= seq_err_s;
      err_timing <= tim_err_s;
      case (state_r)
        ST_SEARCH: begin
          locked <= 1'b0;
          if (chg_s && prev_oh_s && seq_ok_s) begin
            state_r <= ST_SYNC;
          end else begin
            state_r <= ST_SEARCH;
          end
        end
        ST_SYNC: begin
          if (good_step_s) begin
            state_r    <= ST_LOCKED;
            step_pulse <= 1'b1;
            locked     <= 1'b1;
          end else if (chg_s || timeout_s) begin
            state_r <= ST_SEARCH;
            locked  <= 1'b0;
          end else begin
            state_r <= ST_SYNC;
            locked  <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (good_step_s) begin
            state_r    <= ST_LOCKED;
            step_pulse <= 1'b1;
            locked     <= 1'b1;
          end else if (seq_err_s || tim_err_s) begin
            state_r <= ST_SEARCH;
            locked  <= 1'b0;
          end else begin
            state_r <= ST_LOCKED;
            locked  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_SEARCH;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flag; a new error on the same cycle overrides the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky <= 1'b0;
    end else if (seq_err_s || tim_err_s) begin
      err_sticky <= 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
    end else begin
      err_sticky <= err_sticky;
    end
  end

endmodule

// File: tb/tb_led_ring_monitor.sv
// Testbench for led_ring_monitor with C_MAX_COUNT=9, C_TOL=1 (period 9..11 clk).
// A cycle model pushes expected output words to a queue as stimulus is
// driven; they are popped and compared when the DUT produces them.
// Directed checks at key points compare against hand-derived constants.
module tb_led_ring_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] led_in = 16'h0000;
  logic        clr_err = 1'b0;
  logic [3:0]  pos_out;
  logic        pos_valid, step_pulse, err_onehot, err_seq, err_timing, err_sticky, locked;

  led_ring_monitor #(.C_MAX_COUNT(32'd9), .C_TOL(32'd1), .CNT_W(32'd24)) dut (
    .clk(clk), .reset_n(reset_n), .led_in(led_in), .clr_err(clr_err),
    .pos_out(pos_out), .pos_valid(pos_valid), .step_pulse(step_pulse),
    .err_onehot(err_onehot), .err_seq(err_seq), .err_timing(err_timing),
    .err_sticky(err_sticky), .locked(locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [10:0] sb_q[$];

  // Model state: m_q is led as seen by the checker, m_pend the last value driven.
  logic [15:0] m_q, m_pend;
  int          m_cnt, m_st;   // m_st: 0 search, 1 sync, 2 locked
  logic        m_stk;
  logic [3:0]  m_pos;

  function automatic logic [10:0] outs();
    return {pos_out, pos_valid, step_pulse, err_onehot, err_seq, err_timing, err_sticky, locked};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    m_q = 16'h0000; m_pend = 16'h0000; m_cnt = 1; m_st = 0; m_stk = 1'b0; m_pos = 4'd0;
    sb_q.delete();
  endtask

  // One checker cycle: led seen is the value driven a cycle ago, clr is current.
  task automatic model_cycle(input logic clr);
    logic [15:0] prev;
    logic chg, seq, tim, tmo, oh, stp, es, et;
    prev = m_q;
    m_q  = m_pend;
    chg  = (m_q != prev);
    seq  = (m_q == {prev[14:0], prev[15]});
    tim  = (m_cnt + 1 >= 9) && (m_cnt + 1 <= 11);
    tmo  = !chg && (m_cnt + 1 == 11);
    oh   = ($countones(m_q) == 1);
    stp = 1'b0; es = 1'b0; et = 1'b0;
    case (m_st)
      0: if (chg && $countones(prev) == 1 && seq) m_st = 1;
      1: begin
        if (chg && seq && tim) begin m_st = 2; stp = 1'b1; end
        else if (chg || tmo) m_st = 0;
      end
      2: begin
        if (chg && !seq) begin es = 1'b1; m_st = 0; end
        else if (chg && !tim) begin et = 1'b1; m_st = 0; end
        else if (chg) stp = 1'b1;
        else if (tmo) begin et = 1'b1; m_st = 0; end
      end
      default: m_st = 0;
    endcase
    if (es || et) m_stk = 1'b1;
    else if (clr) m_stk = 1'b0;
    if (oh) m_pos = 4'($clog2(m_q));
    m_cnt = chg ? 0 : m_cnt + 1;
    sb_q.push_back({m_pos, oh, stp, !oh, es, et, m_stk, (m_st == 2)});
  endtask

  task automatic cyc(input logic [15:0] x, input logic clr);
    @(negedge clk);
    if (sb_q.size() > 0) check("scoreboard", {5'd0, outs()}, {5'd0, sb_q.pop_front()});
    led_in  = x;
    clr_err = clr;
    model_cycle(clr);
    m_pend = x;
  endtask

  // Drive x for dur clocks; check the outputs produced by its arrival.
  task automatic step(input string tag, input logic [15:0] x, input int dur,
                      input logic e_stp, input logic e_seq, input logic e_tim, input logic e_lck);
    repeat (3) cyc(x, 1'b0);
    check({tag, "/step_pulse"}, {15'd0, step_pulse}, {15'd0, e_stp});
    check({tag, "/err_seq"},    {15'd0, err_seq},    {15'd0, e_seq});
    check({tag, "/err_timing"}, {15'd0, err_timing}, {15'd0, e_tim});
    check({tag, "/locked"},     {15'd0, locked},     {15'd0, e_lck});
    check({tag, "/pos_out"},    {12'd0, pos_out},    16'($clog2(x)));
    repeat (dur - 3) cyc(x, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {5'd0, outs()}, 16'h0000);
    model_init();
    reset_n = 1'b1;

    // 1: rotate every 10 clk through the whole ring
    for (int i = 0; i < 16; i++) begin
      step("rot", 16'h0001 << i, 10, (i >= 2), 1'b0, 1'b0, (i >= 2));
    end
    // 2: legal wrap 0x8000 -> 0x0001
    step("wrap", 16'h0001, 10, 1'b1, 1'b0, 1'b0, 1'b1);
    step("wrap2", 16'h0002, 10, 1'b1, 1'b0, 1'b0, 1'b1);
    step("wrap3", 16'h0004, 10, 1'b1, 1'b0, 1'b0, 1'b1);
    // 3: skip a position -> sequence error, then relock
    step("skip", 16'h0010, 10, 1'b0, 1'b1, 1'b0, 1'b0);
    check("skip/sticky", {15'd0, err_sticky}, 16'd1);
    step("re1", 16'h0020, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("re2", 16'h0040, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    // 4: step after 8 clk -> timing error; relock; then timeout
    step("early", 16'h0080, 10, 1'b0, 1'b0, 1'b1, 1'b0);
    step("re3", 16'h0100, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("re4", 16'h0200, 10, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(16'h0400, 1'b0);
    check("pre_timeout/locked", {15'd0, locked}, 16'd1);
    repeat (11) cyc(16'h0400, 1'b0);
    check("timeout/err_timing", {15'd0, err_timing}, 16'd1);
    check("timeout/locked", {15'd0, locked}, 16'd0);
    cyc(16'h0400, 1'b0);
    check("timeout/pulse_end", {15'd0, err_timing}, 16'd0);
    // 5: non-one-hot patterns; pos_out holds at 10
    repeat (3) cyc(16'h0003, 1'b0);
    check("two_hot/err_onehot", {15'd0, err_onehot}, 16'd1);
    check("two_hot/pos_valid", {15'd0, pos_valid}, 16'd0);
    check("two_hot/pos_out", {12'd0, pos_out}, 16'd10);
    repeat (3) cyc(16'h0000, 1'b0);
    check("zero/err_onehot", {15'd0, err_onehot}, 16'd1);
    check("zero/pos_out", {12'd0, pos_out}, 16'd10);
    cyc(16'h0000, 1'b1);
    repeat (2) cyc(16'h0000, 1'b0);
    check("clr/sticky", {15'd0, err_sticky}, 16'd0);
    step("lk1", 16'h0001, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lk2", 16'h0002, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lk3", 16'h0004, 10, 1'b1, 1'b0, 1'b0, 1'b1);
    // clr_err coincides with the sequence error: set wins
    cyc(16'h000C, 1'b0);
    cyc(16'h000C, 1'b1);
    cyc(16'h000C, 1'b0);
    check("clr_vs_err/err_seq", {15'd0, err_seq}, 16'd1);
    check("clr_vs_err/sticky", {15'd0, err_sticky}, 16'd1);
    cyc(16'h000C, 1'b0);
    check("clr_vs_err/sticky_held", {15'd0, err_sticky}, 16'd1);
    // 6: relock, then asynchronous reset mid-interval
    step("lk4", 16'h0010, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lk5", 16'h0020, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lk6", 16'h0040, 10, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) cyc(16'h0080, 1'b0);
    check("mid/locked", {15'd0, locked}, 16'd1);
    #3 reset_n = 1'b0;
    #1 check("async_reset_outputs", {5'd0, outs()}, 16'h0000);
    sb_q.delete();
    repeat (2) @(negedge clk);
    led_in = 16'h0000; clr_err = 1'b0;
    model_init();
    reset_n = 1'b1;
    step("rr1", 16'h0001, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rr2", 16'h0002, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rr3", 16'h0004, 10, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(16'h0004, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
